// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a DEPTH-entry circular buffer of {pc, instr} pairs
// between fetch and decode, with a valid/ready handshake on each side and a
// synchronous flush for taken branches and jumps.
// Optional macro IF_ID_BYPASS_EN adds a zero-latency pass-through when the
// queue is empty.
module if_id_queue #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          empty_c;
    logic          push_c;
    logic          pop_c;
    logic          write_c;
    logic          adv_rd_c;
    entry_t        head_c;

    assign empty_c  = (cnt_q == '0);
    assign head_c   = mem_q[rd_ptr_q];

    // Ready depends only on occupancy, so a full queue refuses a push even if
    // decode pops in the same cycle.
    assign in_ready = (cnt_q < CW'(DEPTH));
    assign count    = cnt_q;

`ifdef IF_ID_BYPASS_EN
    logic bypass_c;

    // Empty queue with a valid fetch: present the incoming pair directly.
    assign bypass_c  = empty_c & in_valid & ~flush;
    assign out_valid = ~empty_c | bypass_c;
    assign out_pc    = bypass_c ? in_pc    : (empty_c ? 32'h0     : head_c.pc);
    assign out_instr = bypass_c ? in_instr : (empty_c ? NOP_INSTR : head_c.instr);
    assign push_c    = in_valid & in_ready;
    assign pop_c     = out_valid & out_ready;
    // A bypassed pair consumed in the same cycle never touches storage.
    assign write_c   = push_c & ~(bypass_c & out_ready);
    assign adv_rd_c  = pop_c & ~empty_c;
`else
    assign out_valid = ~empty_c;
    assign out_pc    = empty_c ? 32'h0     : head_c.pc;
    assign out_instr = empty_c ? NOP_INSTR : head_c.instr;
    assign push_c    = in_valid & in_ready;
    assign pop_c     = out_valid & out_ready;
    assign write_c   = push_c;
    assign adv_rd_c  = pop_c;
`endif

    // Next-state for pointers and occupancy; flush overrides any push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (write_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (adv_rd_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({write_c, adv_rd_c})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (write_c && !flush) begin
            mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
        end
    end

    // Occupancy can never exceed the buffer size.
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst) cnt_q <= CW'(DEPTH));

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_if_id_queue;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [$clog2(DEPTH):0] count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t model_q[$];
    int   n_checks;
    int   n_pass;

    logic m_push, m_pop, m_flush, m_write;
    ent_t m_in;

    if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: mid-cycle, outputs must match the model's view.
    always @(negedge clk) begin
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        bypass;
        bypass  = 1'b0;
        e_valid = (model_q.size() != 0);
        e_pc    = e_valid ? model_q[0].pc    : 32'h0;
        e_instr = e_valid ? model_q[0].instr : NOP;
`ifdef IF_ID_BYPASS_EN
        if (rst && model_q.size() == 0 && in_valid && !flush) begin
            bypass  = 1'b1;
            e_valid = 1'b1;
            e_pc    = in_pc;
            e_instr = in_instr;
        end
`endif
        check("m_out_valid", 32'(out_valid), 32'(e_valid));
        check("m_in_ready",  32'(in_ready),  32'(model_q.size() < DEPTH));
        check("m_count",     32'(count),     32'(model_q.size()));
        check("m_out_pc",    out_pc,         e_pc);
        check("m_out_instr", out_instr,      e_instr);
        m_push  = in_valid && (model_q.size() < DEPTH);
        m_pop   = e_valid && out_ready;
        m_write = m_push && !(bypass && out_ready);
        m_flush = flush;
        m_in    = '{pc: in_pc, instr: in_instr};
    end

    // Model update on each rising edge using the inputs seen mid-cycle.
    always @(posedge clk) begin
        if (rst) begin
            if (m_flush) begin
                model_q.delete();
            end else begin
                if (m_pop && model_q.size() != 0) void'(model_q.pop_front());
                if (m_write) model_q.push_back(m_in);
            end
        end
    end

    always @(negedge rst) model_q.delete();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_push = 0; m_pop = 0; m_flush = 0; m_write = 0;
        m_in = '{pc: 32'h0, instr: 32'h0};
        rst = 1'b0; flush = 0; in_valid = 0; in_pc = 0; in_instr = 0; out_ready = 0;

        // 1. reset then idle
        repeat (2) step();
        rst = 1'b1;
        step();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_ready", 32'(in_ready),  32'd1);
        check("idle_count", 32'(count),     32'd0);
        check("idle_instr", out_instr,      32'h0000_0013);
        check("idle_pc",    out_pc,         32'h0);

        // 2. basic flow
        in_valid = 1; in_pc = 32'h60; in_instr = 32'h0050_0093;
        step();
        in_valid = 0;
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_pc",    out_pc,         32'h60);
        check("basic_instr", out_instr,      32'h0050_0093);
        check("basic_count", 32'(count),     32'd1);
        out_ready = 1;
        step();
        out_ready = 0;
        check("basic_drain_count", 32'(count),     32'd0);
        check("basic_drain_valid", 32'(out_valid), 32'd0);

        // 3. fill and stall; full queue refuses push despite a pop
        in_valid = 1; in_pc = 32'h60; in_instr = 32'h1;
        step();
        in_pc = 32'h64; in_instr = 32'h2;
        step();
        check("full_count", 32'(count),    32'd2);
        check("full_ready", 32'(in_ready), 32'd0);
        in_pc = 32'h68; in_instr = 32'h3; out_ready = 1;
        step();
        in_valid = 0; out_ready = 0;
        check("refuse_count", 32'(count), 32'd1);
        check("refuse_head",  out_pc,     32'h64);
        out_ready = 1;
        step();
        out_ready = 0;
        check("refuse_drained", 32'(count), 32'd0);

        // 4. streaming with wrap-around
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            in_pc = 32'h60 + 32'(4 * i); in_instr = 32'h100 + 32'(i);
            step();
            check("stream_count", 32'(count), 32'd1);
            check("stream_pc",    out_pc,     32'h60 + 32'(4 * i));
        end
        in_valid = 0;
        step();
        out_ready = 0;
        check("stream_end_count", 32'(count), 32'd0);

        // 5. flush discards contents and the same-cycle push
        in_valid = 1; in_pc = 32'h60; in_instr = 32'h11;
        step();
        in_pc = 32'h64; in_instr = 32'h12;
        step();
        flush = 1; in_pc = 32'h68; in_instr = 32'h13;
        step();
        flush = 0; in_valid = 0;
        check("flush_count", 32'(count),     32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        in_valid = 1; in_pc = 32'h200; in_instr = 32'h14;
        step();
        in_valid = 0;
        check("post_flush_head", out_pc, 32'h200);
        out_ready = 1;
        step();
        out_ready = 0;

        // 6. asynchronous reset between edges
        in_valid = 1; in_pc = 32'h300; in_instr = 32'h21;
        step();
        in_pc = 32'h304; in_instr = 32'h22;
        step();
        in_valid = 0;
        check("pre_rst_count", 32'(count), 32'd2);
        #1 rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(count),     32'd0);
        check("async_rst_instr", out_instr,      NOP);
        step();
        rst = 1'b1;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_pc     = $urandom & 32'hFFFF_FFFC;
            in_instr  = $urandom;
            step();
        end
        in_valid = 0; out_ready = 0; flush = 0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
